// File: rtl/ctrl_seq_pkg.sv
// Shared types and constants for the microcoded control sequencer:
// state encoding, microword field offsets, branch condition codes and strobe presets.
package ctrl_seq_pkg;

  typedef enum logic [2:0] {
    ST_RESET,
    ST_FETCH,
    ST_EXEC,
    ST_HALT_INSTR,
    ST_HALT_DBG
  } seq_state_e;

  typedef enum logic [2:0] {
    COND_ALWAYS = 3'd0,
    COND_Z      = 3'd1,
    COND_C      = 3'd2,
    COND_N      = 3'd3,
    COND_V      = 3'd4,
    COND_NZ     = 3'd5,
    COND_NC     = 3'd6,
    COND_NN     = 3'd7
  } cond_e;

  // Memory controls occupy the low bits of the microword in port order.
  localparam int MEM_WIDTH     = 13;
  localparam int MEM_LSB       = 0;
  localparam int OTHER_LSB     = MEM_WIDTH;
  localparam int COND_WIDTH    = 3;
  localparam int MEM_PC_LOAD_N = 0;
  localparam int MEM_PC_N_EN   = 1;

  // Bit 12..0: ImmToRamAddr, Mar1NWE, Mar0NWE, RamNWE, RamNOE, InstrNOE,
  // InstrNWE, SpNEn, SpUp, MemPCToRamN, PCFromImm, PCNEn, PCLoadN.
  localparam logic [MEM_WIDTH-1:0] CTRL_IDLE  = 13'h0FEB;
  localparam logic [MEM_WIDTH-1:0] CTRL_FETCH = 13'h0FA9;

endpackage

// File: rtl/cond_eval.sv
// Branch condition evaluator: decides whether a conditional microword's
// PC strobes may take effect, given ALU flags {V,N,C,Z}.
module cond_eval
  import ctrl_seq_pkg::*;
(
  input  logic [3:0] i_flags,
  input  logic [2:0] i_cond,
  output logic       o_pass
);

  logic flagZ, flagC, flagN, flagV;

  assign flagZ = i_flags[0];
  assign flagC = i_flags[1];
  assign flagN = i_flags[2];
  assign flagV = i_flags[3];

  always_comb begin
    o_pass = 1'b1;
    case (cond_e'(i_cond))
      COND_ALWAYS: o_pass = 1'b1;
      COND_Z:      o_pass = flagZ;
      COND_C:      o_pass = flagC;
      COND_N:      o_pass = flagN;
      COND_V:      o_pass = flagV;
      COND_NZ:     o_pass = ~flagZ;
      COND_NC:     o_pass = ~flagC;
      COND_NN:     o_pass = ~flagN;
      default:     o_pass = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Microcoded control sequencer: fixed fetch, ROM-driven execute, HLT and
// debugger halt/step/breakpoint. Debug logic is built only when CTRL_SEQ_DEBUG_EN is defined.
module control_sequencer
  import ctrl_seq_pkg::*;
#(
  parameter int STEP_WIDTH  = 4,
  parameter int OTHER_WIDTH = 11
) (
  input  logic                    i_clk,
  input  logic                    i_resetN,
  input  logic [7:0]              i_instrCode,
  input  logic [3:0]              i_flags,
  output logic [8+STEP_WIDTH-1:0] o_ucodeAddress,
  input  logic [OTHER_WIDTH+17:0] i_ucodeData,
  output logic                    o_ctrlPCLoadN,
  output logic                    o_ctrlPCNEn,
  output logic                    o_ctrlPCFromImm,
  output logic                    o_ctrlMemPCToRamN,
  output logic                    o_ctrlSpUp,
  output logic                    o_ctrlSpNEn,
  output logic                    o_ctrlInstrNWE,
  output logic                    o_ctrlInstrNOE,
  output logic                    o_ctrlRamNOE,
  output logic                    o_ctrlRamNWE,
  output logic                    o_ctrlMemMar0NWE,
  output logic                    o_ctrlMemMar1NWE,
  output logic                    o_ctrlMemInstrImmToRamAddr,
  output logic [OTHER_WIDTH-1:0]  o_ctrlOther,
  input  logic                    i_pauseN,
  input  logic                    i_stepN,
  input  logic                    i_breakpointHitN,
  output logic                    o_haltedN,
  output logic [STEP_WIDTH-1:0]   o_step,
  output logic                    o_ucodeErrN
);

  localparam int COND_LSB = OTHER_LSB + OTHER_WIDTH;
  localparam int HALT_BIT = COND_LSB + COND_WIDTH;
  localparam int LAST_BIT = HALT_BIT + 1;

  seq_state_e state, stateNext;
  logic [STEP_WIDTH-1:0] r_step, stepNext;
  logic r_ucodeErrN, errNext;

  logic [MEM_WIDTH-1:0]   memCtrl, wordMem;
  logic [OTHER_WIDTH-1:0] otherCtrl, wordOther;
  logic [COND_WIDTH-1:0]  wordCond;
  logic wordHalt, wordLast, condPass, stepMax, atBoundary;
  logic dbgHalt, dbgResume;

  assign wordMem   = i_ucodeData[MEM_LSB +: MEM_WIDTH];
  assign wordOther = i_ucodeData[OTHER_LSB +: OTHER_WIDTH];
  assign wordCond  = i_ucodeData[COND_LSB +: COND_WIDTH];
  assign wordHalt  = i_ucodeData[HALT_BIT];
  assign wordLast  = i_ucodeData[LAST_BIT];
  assign stepMax   = (r_step == '1);
  // Overflowing the step counter ends the instruction just like a last bit would.
  assign atBoundary = (state == ST_EXEC) && (wordLast || stepMax);

  cond_eval u_condEval (
    .i_flags (i_flags),
    .i_cond  (wordCond),
    .o_pass  (condPass)
  );

`ifdef CTRL_SEQ_DEBUG_EN
  logic r_stepPrevN, r_ssPending, r_bpMask, stepFall;

  assign stepFall  = r_stepPrevN & ~i_stepN;
  assign dbgHalt   = ~i_pauseN | r_ssPending | (~i_breakpointHitN & ~r_bpMask);
  assign dbgResume = stepFall | i_pauseN;

  always_ff @(posedge i_clk) begin
    if (!i_resetN) begin
      r_stepPrevN <= 1'b1;
      r_ssPending <= 1'b0;
      r_bpMask    <= 1'b0;
    end else begin
      r_stepPrevN <= i_stepN;
      if (atBoundary) begin
        r_ssPending <= 1'b0;
        r_bpMask    <= 1'b0;
      end else if (state == ST_HALT_DBG && stepFall) begin
        r_ssPending <= 1'b1;
        r_bpMask    <= 1'b1;
      end else if (state == ST_HALT_DBG && i_pauseN) begin
        r_bpMask    <= 1'b1;
      end
    end
  end
`else
  logic unusedDbg;
  assign unusedDbg = ^{i_pauseN, i_stepN, i_breakpointHitN};
  assign dbgHalt   = 1'b0;
  assign dbgResume = 1'b0;
`endif

  always_comb begin
    stateNext = state;
    stepNext  = r_step;
    errNext   = r_ucodeErrN;
    memCtrl   = CTRL_IDLE;
    otherCtrl = '0;
    case (state)
      ST_RESET: begin
        stepNext  = '0;
        stateNext = ST_FETCH;
      end
      ST_FETCH: begin
        memCtrl   = CTRL_FETCH;
        stepNext  = STEP_WIDTH'(1);
        stateNext = ST_EXEC;
      end
      ST_EXEC: begin
        memCtrl   = wordMem;
        otherCtrl = wordOther;
        if (!condPass) begin
          memCtrl[MEM_PC_LOAD_N] = 1'b1;
          memCtrl[MEM_PC_N_EN]   = 1'b1;
        end
        if (atBoundary) begin
          stepNext = '0;
          if (!wordLast) errNext = 1'b0;
          if (wordLast && wordHalt) stateNext = ST_HALT_INSTR;
          else if (dbgHalt)         stateNext = ST_HALT_DBG;
          else                      stateNext = ST_FETCH;
        end else begin
          stepNext = r_step + STEP_WIDTH'(1);
        end
      end
      ST_HALT_INSTR: stateNext = ST_HALT_INSTR;
      ST_HALT_DBG: begin
        if (dbgResume) stateNext = ST_FETCH;
      end
      default: stateNext = ST_RESET;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_resetN) begin
      state       <= ST_RESET;
      r_step      <= '0;
      r_ucodeErrN <= 1'b1;
    end else begin
      state       <= stateNext;
      r_step      <= stepNext;
      r_ucodeErrN <= errNext;
    end
  end

  assign o_ucodeAddress = {i_instrCode, r_step};
  assign o_step         = r_step;
  assign o_ucodeErrN    = r_ucodeErrN;
  assign o_haltedN      = ~((state == ST_HALT_INSTR) || (state == ST_HALT_DBG));
  assign o_ctrlOther    = otherCtrl;

  assign o_ctrlPCLoadN              = memCtrl[0];
  assign o_ctrlPCNEn                = memCtrl[1];
  assign o_ctrlPCFromImm            = memCtrl[2];
  assign o_ctrlMemPCToRamN          = memCtrl[3];
  assign o_ctrlSpUp                 = memCtrl[4];
  assign o_ctrlSpNEn                = memCtrl[5];
  assign o_ctrlInstrNWE             = memCtrl[6];
  assign o_ctrlInstrNOE             = memCtrl[7];
  assign o_ctrlRamNOE               = memCtrl[8];
  assign o_ctrlRamNWE               = memCtrl[9];
  assign o_ctrlMemMar0NWE           = memCtrl[10];
  assign o_ctrlMemMar1NWE           = memCtrl[11];
  assign o_ctrlMemInstrImmToRamAddr = memCtrl[12];

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: fetch/exec timing, condition table,
// HLT, step overflow and (when CTRL_SEQ_DEBUG_EN is defined) debugger handshake.
module tb_control_sequencer;

  localparam int SW = 4;
  localparam int OW = 11;
  localparam int UW = OW + 18;
  localparam logic [12:0] IDLE  = 13'h0FEB;
  localparam logic [12:0] FETCH = 13'h0FA9;
  localparam logic [12:0] PCGO  = 13'h0FE8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          resetN, pauseN, stepN, bpN;
  logic [7:0]    instrCode;
  logic [3:0]    flags;
  logic [11:0]   ucodeAddress;
  logic [UW-1:0] ucodeData;
  logic [OW-1:0] ctrlOther;
  logic [SW-1:0] step;
  logic          haltedN, ucodeErrN;
  logic pcLoadN, pcNEn, pcFromImm, memPcToRamN, spUp, spNEn, instrNWE, instrNOE;
  logic ramNOE, ramNWE, mar0NWE, mar1NWE, immToRamAddr;
  logic [12:0]   memObs;

  logic [UW-1:0] rom [0:4095];
  assign ucodeData = rom[ucodeAddress];
  assign memObs = {immToRamAddr, mar1NWE, mar0NWE, ramNWE, ramNOE, instrNOE, instrNWE,
                   spNEn, spUp, memPcToRamN, pcFromImm, pcNEn, pcLoadN};

  control_sequencer #(.STEP_WIDTH(SW), .OTHER_WIDTH(OW)) dut (
    .i_clk(clk), .i_resetN(resetN), .i_instrCode(instrCode), .i_flags(flags),
    .o_ucodeAddress(ucodeAddress), .i_ucodeData(ucodeData),
    .o_ctrlPCLoadN(pcLoadN), .o_ctrlPCNEn(pcNEn), .o_ctrlPCFromImm(pcFromImm),
    .o_ctrlMemPCToRamN(memPcToRamN), .o_ctrlSpUp(spUp), .o_ctrlSpNEn(spNEn),
    .o_ctrlInstrNWE(instrNWE), .o_ctrlInstrNOE(instrNOE), .o_ctrlRamNOE(ramNOE),
    .o_ctrlRamNWE(ramNWE), .o_ctrlMemMar0NWE(mar0NWE), .o_ctrlMemMar1NWE(mar1NWE),
    .o_ctrlMemInstrImmToRamAddr(immToRamAddr), .o_ctrlOther(ctrlOther),
    .i_pauseN(pauseN), .i_stepN(stepN), .i_breakpointHitN(bpN),
    .o_haltedN(haltedN), .o_step(step), .o_ucodeErrN(ucodeErrN)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  function automatic logic isFetch();
    return (memObs == FETCH) && (step == 4'd0) && haltedN;
  endfunction

  function automatic logic [UW-1:0] mw(input logic last, input logic halt, input logic [2:0] cond,
                                       input logic [OW-1:0] other, input logic [12:0] mem);
    return {last, halt, cond, other, mem};
  endfunction

  typedef struct {
    logic [7:0] op;
    logic [3:0] flg;
    logic       expPass;
  } condVec_t;

  condVec_t vecs [16];
  int expS [4] = '{1, 2, 3, 0};
  int nF;

  initial begin
    vecs[0]  = '{8'h20, 4'b0000, 1'b1};
    vecs[1]  = '{8'h21, 4'b0000, 1'b0};
    vecs[2]  = '{8'h21, 4'b0001, 1'b1};
    vecs[3]  = '{8'h22, 4'b0010, 1'b1};
    vecs[4]  = '{8'h22, 4'b1101, 1'b0};
    vecs[5]  = '{8'h23, 4'b0100, 1'b1};
    vecs[6]  = '{8'h23, 4'b1011, 1'b0};
    vecs[7]  = '{8'h24, 4'b1000, 1'b1};
    vecs[8]  = '{8'h24, 4'b0111, 1'b0};
    vecs[9]  = '{8'h25, 4'b0000, 1'b1};
    vecs[10] = '{8'h25, 4'b0001, 1'b0};
    vecs[11] = '{8'h26, 4'b1101, 1'b1};
    vecs[12] = '{8'h26, 4'b0010, 1'b0};
    vecs[13] = '{8'h27, 4'b1011, 1'b1};
    vecs[14] = '{8'h27, 4'b0100, 1'b0};
    vecs[15] = '{8'h20, 4'b1111, 1'b1};

    for (int a = 0; a < 4096; a++) rom[a] = mw(1'b1, 1'b0, 3'd0, 11'h0, IDLE);
    rom[{8'h10, 4'd1}] = mw(1'b0, 1'b0, 3'd0, 11'd1, IDLE);
    rom[{8'h10, 4'd2}] = mw(1'b0, 1'b0, 3'd0, 11'd2, IDLE);
    rom[{8'h10, 4'd3}] = mw(1'b1, 1'b0, 3'd0, 11'd3, IDLE);
    for (int k = 0; k < 8; k++) rom[{8'h20 + 8'(k), 4'd1}] = mw(1'b1, 1'b0, 3'(k), 11'h5A5, PCGO);
    rom[{8'h30, 4'd1}] = mw(1'b0, 1'b1, 3'd0, 11'h33, IDLE);
    rom[{8'h30, 4'd2}] = mw(1'b1, 1'b0, 3'd0, 11'h44, IDLE);
    for (int s = 1; s < 16; s++) rom[{8'h40, 4'(s)}] = mw(1'b0, 1'b0, 3'd0, 11'(s), IDLE);
    rom[{8'hFF, 4'd1}] = mw(1'b0, 1'b0, 3'd0, 11'h11, IDLE);
    rom[{8'hFF, 4'd2}] = mw(1'b1, 1'b1, 3'd0, 11'h22, IDLE);

    resetN = 1'b0; pauseN = 1'b1; stepN = 1'b1; bpN = 1'b1;
    instrCode = 8'h10; flags = 4'b0000;

    // Reset held three cycles, then release.
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("rst_mem", 32'(memObs), 32'(IDLE));
      chk("rst_other", 32'(ctrlOther), 32'h0);
      chk("rst_flags", {29'h0, haltedN, ucodeErrN, step == 4'd0}, 32'h7);
    end
    resetN = 1'b1;
    #1;
    chk("rel_idle", 32'(memObs), 32'(IDLE));
    tick;
    chk("fetch_mem", 32'(memObs), 32'(FETCH));
    chk("fetch_addr", 32'(ucodeAddress), 32'h100);

    // Opcode 0x10: last on step 3, four cycles including fetch.
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("seq_step", 32'(step), 32'(expS[i]));
      if (i == 0) chk("seq_addr", 32'(ucodeAddress), 32'h101);
      if (i < 3) chk("seq_other", 32'(ctrlOther), 32'(expS[i]));
      else chk("seq_refetch", 32'(isFetch()), 32'h1);
    end

    // Conditional PC strobes against every condition code.
    for (int v = 0; v < 16; v++) begin
      instrCode = vecs[v].op;
      flags = vecs[v].flg;
      tick;
      chk("cond_addr", 32'(ucodeAddress), {20'h0, vecs[v].op, 4'd1});
      chk("cond_mem", 32'(memObs), vecs[v].expPass ? 32'(PCGO) : 32'(IDLE));
      chk("cond_other", 32'(ctrlOther), 32'h5A5);
      tick;
    end
    flags = 4'b0000;

    // Halt bit without last is ignored.
    instrCode = 8'h30;
    tick;
    chk("hnl_other", 32'(ctrlOther), 32'h33);
    tick;
    chk("hnl_s2", 32'(ctrlOther), 32'h44);
    tick;
    chk("hnl_fetch", 32'(isFetch()), 32'h1);

    // Step overflow: no last bit in 15 steps.
    instrCode = 8'h40;
    for (int s = 1; s < 16; s++) begin
      tick;
      chk("ovf_step", 32'(step), 32'(s));
      chk("ovf_other", 32'(ctrlOther), 32'(s));
    end
    chk("ovf_err_pre", 32'(ucodeErrN), 32'h1);
    tick;
    chk("ovf_fetch", 32'(isFetch()), 32'h1);
    chk("ovf_err", 32'(ucodeErrN), 32'h0);
    instrCode = 8'h01;
    tick;
    tick;
    chk("ovf_sticky", {30'h0, ucodeErrN, isFetch()}, 32'h1);

    // HLT on step 2 of 0xFF.
    instrCode = 8'hFF;
    tick;
    tick;
    chk("hlt_exec", {30'h0, haltedN, ctrlOther == 11'h22}, 32'h3);
    for (int i = 0; i < 6; i++) begin
      tick;
      chk("hlt_state", {18'h0, haltedN, memObs}, {18'h0, 1'b0, IDLE});
      chk("hlt_other", {27'h0, ctrlOther == 11'h0, step}, 32'h10);
      pauseN = ~pauseN; stepN = ~stepN; bpN = ~bpN;
    end
    pauseN = 1'b1; stepN = 1'b1; bpN = 1'b1;
    resetN = 1'b0;
    tick;
    resetN = 1'b1;
    #1;
    chk("hlt_rst", {29'h0, haltedN, ucodeErrN, memObs == IDLE}, 32'h7);
    tick;
    chk("hlt_recover", 32'(isFetch()), 32'h1);

`ifdef CTRL_SEQ_DEBUG_EN
    // Pause halt, single step, then breakpoint skipped once on resume.
    instrCode = 8'h01;
    pauseN = 1'b0;
    tick;
    tick;
    chk("dbg_halt", 32'(haltedN), 32'h0);
    tick;
    chk("dbg_hold", {18'h0, haltedN, memObs}, {18'h0, 1'b0, IDLE});
    stepN = 1'b0;
    nF = 0;
    for (int i = 1; i <= 6; i++) begin
      tick;
      if (isFetch()) nF++;
      if (i == 1) chk("dbg_step_fetch", 32'(isFetch()), 32'h1);
      if (i == 2) stepN = 1'b1;
      if (i >= 3) chk("dbg_rehalt", 32'(haltedN), 32'h0);
    end
    chk("dbg_one_instr", 32'(nF), 32'd1);
    bpN = 1'b0;
    pauseN = 1'b1;
    nF = 0;
    for (int i = 1; i <= 5; i++) begin
      tick;
      if (i <= 4 && isFetch()) nF++;
      if (i <= 4) chk("dbg_run", 32'(haltedN), 32'h1);
    end
    chk("dbg_bp_masked", 32'(nF), 32'd2);
    chk("dbg_bp_halt", 32'(haltedN), 32'h0);
    bpN = 1'b1;
    tick;
    chk("dbg_resume", 32'(isFetch()), 32'h1);
`else
    // Debug inputs have no effect in this build.
    instrCode = 8'h01;
    pauseN = 1'b0; bpN = 1'b0; stepN = 1'b0;
    nF = 0;
    for (int i = 1; i <= 4; i++) begin
      tick;
      chk("nodbg_run", 32'(haltedN), 32'h1);
      if (isFetch()) nF++;
      stepN = ~stepN;
    end
    chk("nodbg_fetches", 32'(nF), 32'd2);
    pauseN = 1'b1; bpN = 1'b1; stepN = 1'b1;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
